// File: rtl/neokeon_decrypt_iter_if.sv
// Block-level bundle between the key/ciphertext register file, the Neokeon decryptor
// and the plaintext output buffer: valid/ready on the input side, valid/ack on the output side.
interface neokeon_decrypt_iter_if;
  logic         inValid;
  logic         outReady;
  logic [127:0] inKey;
  logic [127:0] inData;
  logic         outValid;
  logic         inAck;
  logic [127:0] outData;

  modport slave (
    input  inValid,
    input  inKey,
    input  inData,
    input  inAck,
    output outReady,
    output outValid,
    output outData
  );

  modport master (
    output inValid,
    output inKey,
    output inData,
    output inAck,
    input  outReady,
    input  outValid,
    input  outData
  );
endinterface

// File: rtl/neokeon_decrypt_iter.sv
// Iterative Neokeon-128 decryption core: one round per clock, 16 rounds plus a final Theta.
// Optional macro NEOKEON_DEC_KEY_CACHE_EN retains the working key across blocks sharing a key.
module neokeon_decrypt_iter #(
  parameter int NR = 16,
  parameter int W  = 32
) (
  input logic                   inClk,
  input logic                   inRstN,
  neokeon_decrypt_iter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    KEYSCHED = 3'd1,
    ROUND    = 3'd2,
    FINAL    = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam int         BW         = 4 * W;
  localparam logic [3:0] LAST_ROUND = 4'(NR - 1);
  localparam logic [4:0] RC_FIRST   = 5'(NR);

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int n);
    return (x << n) | (x >> (W - n));
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
    return (x >> n) | (x << (W - n));
  endfunction

  function automatic logic [BW-1:0] theta(input logic [BW-1:0] k, input logic [BW-1:0] s);
    logic [W-1:0] a0, a1, a2, a3, t;
    a0 = s[4*W-1:3*W];
    a1 = s[3*W-1:2*W];
    a2 = s[2*W-1:W];
    a3 = s[W-1:0];
    t  = a0 ^ a2;
    t  = t ^ rotl(t, 8) ^ rotr(t, 8);
    a1 = a1 ^ t;
    a3 = a3 ^ t;
    a0 = a0 ^ k[4*W-1:3*W];
    a1 = a1 ^ k[3*W-1:2*W];
    a2 = a2 ^ k[2*W-1:W];
    a3 = a3 ^ k[W-1:0];
    t  = a1 ^ a3;
    t  = t ^ rotl(t, 8) ^ rotr(t, 8);
    a0 = a0 ^ t;
    a2 = a2 ^ t;
    return {a0, a1, a2, a3};
  endfunction

  function automatic logic [BW-1:0] pi1(input logic [BW-1:0] s);
    return {s[4*W-1:3*W], rotl(s[3*W-1:2*W], 1), rotl(s[2*W-1:W], 5), rotl(s[W-1:0], 2)};
  endfunction

  function automatic logic [BW-1:0] pi2(input logic [BW-1:0] s);
    return {s[4*W-1:3*W], rotr(s[3*W-1:2*W], 1), rotr(s[2*W-1:W], 5), rotr(s[W-1:0], 2)};
  endfunction

  // Gamma is its own inverse, so the same nonlinear step serves both directions.
  function automatic logic [BW-1:0] gamma(input logic [BW-1:0] s);
    logic [W-1:0] a0, a1, a2, a3, tmp;
    a0  = s[4*W-1:3*W];
    a1  = s[3*W-1:2*W];
    a2  = s[2*W-1:W];
    a3  = s[W-1:0];
    a1  = a1 ^ (~a3 & ~a2);
    a0  = a0 ^ (a2 & a1);
    tmp = a3;
    a3  = a0;
    a0  = tmp;
    a2  = a2 ^ a0 ^ a1 ^ a3;
    a1  = a1 ^ (~a3 & ~a2);
    a0  = a0 ^ (a2 & a1);
    return {a0, a1, a2, a3};
  endfunction

  function automatic logic [BW-1:0] dec_round(input logic [BW-1:0] s, input logic [BW-1:0] k,
                                              input logic [7:0] c);
    logic [BW-1:0] x;
    x = theta(k, s);
    x[3*W+7:3*W] = x[3*W+7:3*W] ^ c;
    return pi2(gamma(pi1(x)));
  endfunction

  function automatic logic [7:0] rc_rom(input logic [4:0] idx);
    logic [7:0] c;
    case (idx)
      5'd0:    c = 8'h80;
      5'd1:    c = 8'h1B;
      5'd2:    c = 8'h36;
      5'd3:    c = 8'h6C;
      5'd4:    c = 8'hD8;
      5'd5:    c = 8'hAB;
      5'd6:    c = 8'h4D;
      5'd7:    c = 8'h9A;
      5'd8:    c = 8'h2F;
      5'd9:    c = 8'h5E;
      5'd10:   c = 8'hBC;
      5'd11:   c = 8'h63;
      5'd12:   c = 8'hC6;
      5'd13:   c = 8'h97;
      5'd14:   c = 8'h35;
      5'd15:   c = 8'h6A;
      5'd16:   c = 8'hD4;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [BW-1:0] st, st_n;
  logic [BW-1:0] wk, wk_n;
  logic [BW-1:0] key_q, key_n;
  logic [BW-1:0] data_q, data_n;
  logic          valid_q, valid_n;
  logic          ready_q, ready_n;
  logic [7:0]    rc;
  logic [BW-1:0] round_out;
  logic [BW-1:0] final_out;
  logic          key_hit;

`ifdef NEOKEON_DEC_KEY_CACHE_EN
  logic cache_vld, cache_n;

  assign key_hit = cache_vld && (bus.inKey == key_q);
`else
  assign key_hit = 1'b0;
`endif

  // Round constant for the current cycle: descending from RC[NR], RC[0] in FINAL.
  always_comb begin
    if (state == FINAL) begin
      rc = rc_rom(5'd0);
    end else begin
      rc = rc_rom(RC_FIRST - {1'b0, cnt});
    end
  end

  // Datapath results for ROUND and FINAL cycles.
  always_comb begin
    round_out = dec_round(st, wk, rc);
    final_out = theta(wk, st);
    final_out[3*W+7:3*W] = final_out[3*W+7:3*W] ^ rc;
  end

  // Next-state and next-register logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    st_n    = st;
    wk_n    = wk;
    key_n   = key_q;
    data_n  = data_q;
    valid_n = valid_q;
    ready_n = ready_q;
`ifdef NEOKEON_DEC_KEY_CACHE_EN
    cache_n = cache_vld;
`endif
    case (state)
      IDLE: begin
        if (bus.inValid && ready_q) begin
          key_n   = bus.inKey;
          st_n    = bus.inData;
          ready_n = 1'b0;
          cnt_n   = 4'd0;
`ifdef NEOKEON_DEC_KEY_CACHE_EN
          cache_n = key_hit;
`endif
          if (key_hit) begin
            state_n = ROUND;
          end else begin
            state_n = KEYSCHED;
          end
        end else begin
          state_n = IDLE;
        end
      end
      KEYSCHED: begin
        // Working key is Theta of K under a null key (K passed as the state).
        wk_n    = theta({BW{1'b0}}, key_q);
        cnt_n   = 4'd0;
        state_n = ROUND;
`ifdef NEOKEON_DEC_KEY_CACHE_EN
        cache_n = 1'b1;
`endif
      end
      ROUND: begin
        st_n  = round_out;
        cnt_n = cnt + 4'd1;
        if (cnt == LAST_ROUND) begin
          state_n = FINAL;
        end else begin
          state_n = ROUND;
        end
      end
      FINAL: begin
        st_n    = final_out;
        data_n  = final_out;
        valid_n = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        if (bus.inAck) begin
          valid_n = 1'b0;
          ready_n = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        valid_n = 1'b0;
        ready_n = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Datapath, key and registered handshake outputs.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      cnt     <= 4'd0;
      st      <= {BW{1'b0}};
      wk      <= {BW{1'b0}};
      key_q   <= {BW{1'b0}};
      data_q  <= {BW{1'b0}};
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      cnt     <= cnt_n;
      st      <= st_n;
      wk      <= wk_n;
      key_q   <= key_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      ready_q <= ready_n;
    end
  end

`ifdef NEOKEON_DEC_KEY_CACHE_EN
  // Cache validity: set once WK is derived, cleared by a key mismatch or reset.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      cache_vld <= 1'b0;
    end else begin
      cache_vld <= cache_n;
    end
  end
`endif

  assign bus.outReady = ready_q;
  assign bus.outValid = valid_q;
  assign bus.outData  = data_q;

endmodule

// File: tb/tb_neokeon_decrypt_iter.sv
// Self-checking bench for neokeon_decrypt_iter: ciphertexts come from an in-bench Neokeon
// encryptor; decryption must return the original plaintext with the expected latency.
module tb_neokeon_decrypt_iter;

  localparam logic [7:0] RC_TAB [17] = '{8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A,
                                         8'h2F, 8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A,
                                         8'hD4};

  typedef struct packed {
    logic [127:0] key;
    logic [127:0] pt;
    logic         ack_early;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic         cache_ok;
  logic [127:0] cache_key;

  neokeon_decrypt_iter_if ifc ();

  neokeon_decrypt_iter dut (
    .inClk  (clk),
    .inRstN (rst_n),
    .bus    (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] m_theta(input logic [127:0] k, input logic [127:0] s);
    logic [31:0] a [4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) a[i] = s[127 - 32*i -: 32];
    t = a[0] ^ a[2];
    t = t ^ rl(t, 8) ^ rl(t, 24);
    a[1] = a[1] ^ t;
    a[3] = a[3] ^ t;
    for (int i = 0; i < 4; i++) a[i] = a[i] ^ k[127 - 32*i -: 32];
    t = a[1] ^ a[3];
    t = t ^ rl(t, 8) ^ rl(t, 24);
    a[0] = a[0] ^ t;
    a[2] = a[2] ^ t;
    return {a[0], a[1], a[2], a[3]};
  endfunction

  function automatic logic [127:0] m_pgp(input logic [127:0] s);
    logic [31:0] a0, a1, a2, a3, tmp;
    {a0, a1, a2, a3} = s;
    a1 = rl(a1, 1);
    a2 = rl(a2, 5);
    a3 = rl(a3, 2);
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    tmp = a3;
    a3 = a0;
    a0 = tmp;
    a2 = a2 ^ a0 ^ a1 ^ a3;
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    a1 = rl(a1, 31);
    a2 = rl(a2, 27);
    a3 = rl(a3, 30);
    return {a0, a1, a2, a3};
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] s;
    s = p;
    for (int r = 0; r < 16; r++) begin
      s[103:96] = s[103:96] ^ RC_TAB[r];
      s = m_theta(k, s);
      s = m_pgp(s);
    end
    s[103:96] = s[103:96] ^ RC_TAB[16];
    return m_theta(k, s);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_block(input string name, input logic [127:0] key, input logic [127:0] pt,
                           input logic ack_early, input logic do_ack, input logic probe);
    logic [127:0] ct;
    logic [7:0]   rcs [41];
    int           cyc;
    int           exp_lat;
    ct      = encrypt(key, pt);
    exp_lat = 18;
`ifdef NEOKEON_DEC_KEY_CACHE_EN
    if (cache_ok && key == cache_key) exp_lat = 17;
    cache_ok  = 1'b1;
    cache_key = key;
`endif
    @(negedge clk);
    check({name, " ready"}, 128'(ifc.outReady), 128'd1);
    ifc.inKey   = key;
    ifc.inData  = ct;
    ifc.inValid = 1'b1;
    ifc.inAck   = ack_early;
    @(posedge clk);
    #1;
    ifc.inValid = 1'b0;
    ifc.inKey   = ~key;
    ifc.inData  = ~ct;
    cyc = 0;
    while (!ifc.outValid && cyc < 40) begin
      rcs[cyc] = dut.rc;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, " latency"}, 128'(cyc), 128'(exp_lat));
    check({name, " data"}, ifc.outData, pt);
    if (probe) begin
      for (int j = 0; j < 17; j++) begin
        check($sformatf("%s rc%0d", name, j), 128'(rcs[exp_lat - 17 + j]), 128'(RC_TAB[16 - j]));
      end
    end
    if (do_ack) begin
      ifc.inAck = 1'b1;
      @(posedge clk);
      #1;
      ifc.inAck = 1'b0;
      check({name, " ack valid"}, 128'(ifc.outValid), 128'd0);
      check({name, " ack ready"}, 128'(ifc.outReady), 128'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t         vecs [5];
    logic [127:0] ct;
    errors      = 0;
    checks      = 0;
    cache_ok    = 1'b0;
    cache_key   = 128'd0;
    vecs[0] = '{key: 128'h0, pt: 128'h0, ack_early: 1'b0};
    vecs[1] = '{key: 128'h0, pt: 128'h0123456789abcdeffedcba9876543210, ack_early: 1'b1};
    vecs[2] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                pt:  128'h00112233445566778899aabbccddeeff, ack_early: 1'b0};
    vecs[3] = '{key: {128{1'b1}}, pt: {128{1'b1}}, ack_early: 1'b1};
    vecs[4] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                pt:  128'h6bc1bee22e409f96e93d7e117393172a, ack_early: 1'b0};

    rst_n       = 1'b0;
    ifc.inValid = 1'b0;
    ifc.inAck   = 1'b0;
    ifc.inKey   = 128'd0;
    ifc.inData  = 128'd0;
    #12;
    check("reset valid", 128'(ifc.outValid), 128'd0);
    check("reset ready", 128'(ifc.outReady), 128'd1);
    check("reset data", ifc.outData, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_block($sformatf("vec%0d", v), vecs[v].key, vecs[v].pt, vecs[v].ack_early, 1'b1, 1'b1);
    end

    // Output held for 10 cycles without ack; an inValid pulse in that window must be ignored.
    run_block("hold", vecs[2].key, vecs[2].pt, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        ifc.inValid = 1'b1;
        ifc.inKey   = vecs[4].key;
        ifc.inData  = vecs[4].pt;
      end else begin
        ifc.inValid = 1'b0;
      end
      @(posedge clk);
      #1;
      check("hold valid", 128'(ifc.outValid), 128'd1);
      check("hold ready", 128'(ifc.outReady), 128'd0);
      check("hold data", ifc.outData, vecs[2].pt);
    end
    ifc.inValid = 1'b0;
    ifc.inAck   = 1'b1;
    @(posedge clk);
    #1;
    ifc.inAck = 1'b0;
    check("hold ack valid", 128'(ifc.outValid), 128'd0);
    check("hold ack ready", 128'(ifc.outReady), 128'd1);

    // Reset in the middle of the rounds discards the block and restores reset values.
    ct = encrypt(vecs[4].key, vecs[4].pt);
    @(negedge clk);
    ifc.inKey   = vecs[4].key;
    ifc.inData  = ct;
    ifc.inValid = 1'b1;
    @(posedge clk);
    #1;
    ifc.inValid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst valid", 128'(ifc.outValid), 128'd0);
    check("midrst ready", 128'(ifc.outReady), 128'd1);
    check("midrst data", ifc.outData, 128'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    cache_ok = 1'b0;
    run_block("postrst", vecs[4].key, vecs[4].pt, 1'b0, 1'b1, 1'b0);
    run_block("postrst2", vecs[4].key, vecs[2].pt, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
